// File: rtl/ps2_transmitter.sv
// PS/2 device-to-host byte transmitter: drives the open-drain clock/data pair with an
// 11-bit odd-parity frame. Define PS2_TX_RETRY_EN to resend inhibited frames instead of aborting.
module ps2_transmitter #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [HW-1:0] HP_LAST   = HW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [3:0]    STOP_BIT  = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      data_sync_q, data_sync_d;
    logic [7:0]      data_q, data_d;
    logic [3:0]      bit_q, bit_d;
    logic [HW-1:0]   hp_cnt_q, hp_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            tx_ready_q, tx_ready_d;
    logic            tx_done_q, tx_done_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic [10:0]     frame;
    logic [3:0]      next_bit;
    logic            clk_s;
    logic            data_s;
`ifndef PS2_TX_RETRY_EN
    logic            tx_abort_q, tx_abort_d;
`endif

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    // stop, odd parity, data LSB first, start
    assign frame    = {1'b1, ~^data_q, data_q, 1'b0};
    assign next_bit = bit_q + 4'd1;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        state_d     = state_q;
        data_d      = data_q;
        bit_d       = bit_q;
        hp_cnt_d    = hp_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        tx_ready_d  = tx_ready_q;
        tx_done_d   = 1'b0;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
`ifndef PS2_TX_RETRY_EN
        tx_abort_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    data_d     = tx_data;
                    idle_cnt_d = '0;
                    tx_ready_d = 1'b0;
                    state_d    = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d   = S_HIGH;
                        bit_d     = '0;
                        hp_cnt_d  = '0;
                        clk_oe_d  = 1'b0;
                        data_oe_d = ~frame[0];
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            S_HIGH: begin
                if (hp_cnt_q == HP_LAST) begin
                    hp_cnt_d = '0;
                    if (!clk_s) begin
                        // host is inhibiting: release both lines straight away
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                        idle_cnt_d = '0;
                        state_d    = S_WAIT_IDLE;
`else
                        tx_abort_d = 1'b1;
                        tx_ready_d = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        clk_oe_d = 1'b1;
                        state_d  = S_LOW;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end
            S_LOW: begin
                if (hp_cnt_q == HP_LAST) begin
                    hp_cnt_d = '0;
                    clk_oe_d = 1'b0;
                    if (bit_q == STOP_BIT) begin
                        data_oe_d = 1'b0;
                        tx_done_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        bit_d     = next_bit;
                        data_oe_d = ~frame[next_bit];
                        state_d   = S_HIGH;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end
            S_DONE: begin
                tx_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                tx_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            data_q      <= '0;
            bit_q       <= '0;
            hp_cnt_q    <= '0;
            idle_cnt_q  <= '0;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
`ifndef PS2_TX_RETRY_EN
            tx_abort_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            data_q      <= data_d;
            bit_q       <= bit_d;
            hp_cnt_q    <= hp_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
`ifndef PS2_TX_RETRY_EN
            tx_abort_q  <= tx_abort_d;
`endif
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_done     = tx_done_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
`ifdef PS2_TX_RETRY_EN
    assign tx_abort    = 1'b0;
`else
    assign tx_abort    = tx_abort_q;
`endif

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter (HALF_PERIOD=4, IDLE_CYCLES=6) with an open-drain line
// model and a host that samples data on every falling edge of the PS/2 clock line.
module tb_ps2_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_abort;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       host_clk_low = 1'b0;
    wire        clk_line  = ~(ps2_clk_oe | host_clk_low);
    wire        data_line = ~ps2_data_oe;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cap_cnt = 0;
    int         done_cnt = 0;
    logic       cap_mem [0:255];

    ps2_transmitter #(.HALF_PERIOD(4), .IDLE_CYCLES(6)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_abort(tx_abort),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk_line) begin
        if (cap_cnt < 256) cap_mem[cap_cnt] = data_line;
        cap_cnt = cap_cnt + 1;
    end

    always @(negedge clk) if (tx_done) done_cnt = done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] get_frame(input int base);
        logic [10:0] f;
        for (int i = 0; i < 11; i++) f[i] = cap_mem[base + i];
        return f;
    endfunction

    task automatic start_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_ready_low", {31'd0, tx_ready}, 32'd0);
    endtask

    // Waits for the start bit, then expects tx_done exactly 88 cycles later.
    task automatic finish_frame(input int base, input logic [10:0] exp, input string tag);
        int n;
        n = 0;
        while (ps2_data_oe !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, {31'd0, n < 300}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done !== 1'b1 && n < 300);
        chk({tag, "_len"}, n, 32'd88);
        chk({tag, "_bits"}, cap_cnt - base, 32'd11);
        chk({tag, "_frame"}, {21'd0, get_frame(base)}, {21'd0, exp});
        @(negedge clk);
        chk({tag, "_done_single"}, {31'd0, tx_done}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int d0;
        logic oe_seen;
        logic pulse_seen;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_abort", {31'd0, tx_abort}, 32'd0);
        chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0xAA: 0,0,1,0,1,0,1,0,1,1,1
        base = cap_cnt;
        start_byte(8'hAA);
        finish_frame(base, 11'b111_0101_0100, "aa");

        // 0x07: 0,1,1,1,0,0,0,0,0,0,1 (parity 0)
        base = cap_cnt;
        start_byte(8'h07);
        finish_frame(base, 11'b100_0000_1110, "07");

        // host holds clock low; 2 sync stages + 6 idle cycles before the start bit
        host_clk_low = 1'b1;
        start_byte(8'h55);
        oe_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            oe_seen |= ps2_clk_oe | ps2_data_oe;
        end
        chk("inhibit_no_oe", {31'd0, oe_seen}, 32'd0);
        host_clk_low = 1'b0;
        base = cap_cnt;
        n = 0;
        while (ps2_data_oe !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_cycles", n, 32'd8);
        finish_frame(base, 11'b110_1010_1010, "55");

        // host inhibits during the HIGH phase of bit 4 of 0x3C
        base = cap_cnt;
        start_byte(8'h3C);
        n = 0;
        while (!((cap_cnt - base) == 4 && ps2_clk_oe == 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bit4_reached", {31'd0, n < 400}, 32'd1);
        host_clk_low = 1'b1;
        pulse_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            pulse_seen |= tx_abort;
        end
        chk("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
`ifdef PS2_TX_RETRY_EN
        chk("retry_no_abort", {31'd0, pulse_seen}, 32'd0);
        chk("retry_ready_low", {31'd0, tx_ready}, 32'd0);
        repeat (5) @(negedge clk);
        host_clk_low = 1'b0;
        base = cap_cnt;
        finish_frame(base, 11'b110_0111_1000, "3c_retry");
`else
        chk("abort_pulse", {31'd0, tx_abort}, 32'd1);
        @(negedge clk);
        chk("abort_single", {31'd0, tx_abort}, 32'd0);
        chk("abort_ready", {31'd0, tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
        host_clk_low = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // reset during bit 6 of 0xAA
        base = cap_cnt;
        d0 = done_cnt;
        start_byte(8'hAA);
        n = 0;
        while (!((cap_cnt - base) == 6 && ps2_clk_oe == 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bit6_reached", {31'd0, n < 400}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        pulse_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pulse_seen |= tx_done | tx_abort;
        end
        chk("rst_mid_no_pulse", {31'd0, pulse_seen}, 32'd0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        base = cap_cnt;
        start_byte(8'h12);
        finish_frame(base, 11'b110_0010_0100, "12");
        chk("rst_mid_done_cnt", done_cnt - d0, 32'd1);

        // back-to-back 0x01 then 0x02 with tx_valid held high
        base = cap_cnt;
        d0 = done_cnt;
        @(negedge clk);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready !== 1'b0 && n < 20);
        tx_data = 8'h02;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        while (tx_ready !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        while ((done_cnt - d0) < 2 && n < 800) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        chk("b2b_done_cnt", done_cnt - d0, 32'd2);
        chk("b2b_bits", cap_cnt - base, 32'd22);
        chk("b2b_frame1", {21'd0, get_frame(base)}, {21'd0, 11'b100_0000_0010});
        chk("b2b_frame2", {21'd0, get_frame(base + 11)}, {21'd0, 11'b100_0000_0100});
        chk("b2b_idle_ready", {31'd0, tx_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
